// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for truth-table characterisation tooling.
// Bit mapping: vector idx lands in truth_table bit (7 - idx), MSB first.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 8;

    function automatic logic [2:0] tt_bit(input logic [2:0] idx);
        return 3'd7 - idx;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle-window counter: counts while enabled, expire flags the last cycle
// of the window so the owner can sample and clear in the same edge.
module settle_timer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps the 8 input vectors of a 3-input gate, samples its output after a
// settle window and compares the assembled truth table to an expected code.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    output logic       gate_in1,
    output logic       gate_in2,
    output logic       gate_in3,
    input  logic       gate_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       pass,
    output state_t     dbg_state
);

    // Handshake: start is a single-cycle request taken only in IDLE with abort
    // low; there is no ready, requests elsewhere are dropped, never queued.
    // done is a one-cycle valid for truth_table/pass, which hold until the next start.

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] tt_q, tt_d;
    logic [7:0] exp_code_q, exp_code_d;
    logic       pass_q, pass_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       timer_clr, timer_en, expire;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .expire(expire)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tt_d       = tt_q;
        exp_code_d = exp_code_q;
        pass_d     = pass_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timer_en   = 1'b0;
        timer_clr  = 1'b1;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = SETTLE;
                    exp_code_d = expected;
                    tt_d       = 8'h00;
                    pass_d     = 1'b0;
                    idx_d      = 3'd0;
                    busy_d     = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    idx_d   = 3'd0;
                    tt_d    = 8'h00;
                    pass_d  = 1'b0;
                end else begin
                    timer_en  = 1'b1;
                    timer_clr = 1'b0;
                    if (expire) begin
                        // Sample, restart the window and move to the next vector together.
                        tt_d[tt_bit(idx_q)] = gate_out;
                        timer_clr           = 1'b1;
                        if (idx_q == 3'(NUM_VECTORS - 1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            pass_d  = (tt_d == exp_code_q);
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                idx_d   = 3'd0;
                if (abort) begin
                    tt_d   = 8'h00;
                    pass_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            tt_q       <= 8'h00;
            exp_code_q <= 8'h00;
            pass_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tt_q       <= tt_d;
            exp_code_q <= exp_code_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // The vector register is the index itself, so it is zero whenever idle.
    assign {gate_in1, gate_in2, gate_in3} = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tt_q;
    assign pass        = pass_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: two sweepers (settle 4 and settle 1) each driving a
// combinational gate model built from an 8-bit code.
module tb_truth_table_sweeper;
    import tt_sweep_pkg::*;

    localparam int S_A = 4;
    localparam int S_B = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
    logic [7:0] expected = 8'h00;
    logic [7:0] code_a = 8'h00, code_b = 8'h00;

    logic       a_in1, a_in2, a_in3, a_out, a_busy, a_done, a_pass;
    logic       b_in1, b_in2, b_in3, b_out, b_busy, b_done, b_pass;
    logic [7:0] a_tt, b_tt;
    state_t     a_st, b_st;

    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    bit         sel = 1'b0;

    logic [2:0] vec_v;
    logic       busy_v, done_v, pass_v;
    logic [7:0] tt_v;
    state_t     st_v;

    // Gate models: output for vector v is code bit (7 - v).
    assign a_out = code_a[3'd7 - {a_in1, a_in2, a_in3}];
    assign b_out = code_b[3'd7 - {b_in1, b_in2, b_in3}];

    assign vec_v  = sel ? {b_in1, b_in2, b_in3} : {a_in1, a_in2, a_in3};
    assign busy_v = sel ? b_busy : a_busy;
    assign done_v = sel ? b_done : a_done;
    assign pass_v = sel ? b_pass : a_pass;
    assign tt_v   = sel ? b_tt : a_tt;
    assign st_v   = sel ? b_st : a_st;

    truth_table_sweeper #(.SETTLE_CYCLES(S_A), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .expected(expected),
        .gate_in1(a_in1), .gate_in2(a_in2), .gate_in3(a_in3), .gate_out(a_out),
        .busy(a_busy), .done(a_done), .truth_table(a_tt), .pass(a_pass), .dbg_state(a_st)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(S_B), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .expected(expected),
        .gate_in1(b_in1), .gate_in2(b_in2), .gate_in3(b_in3), .gate_out(b_out),
        .busy(b_busy), .done(b_done), .truth_table(b_tt), .pass(b_pass), .dbg_state(b_st)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy_v), 32'(0));
        check_eq({tag, "_done"}, 32'(done_v), 32'(0));
        check_eq({tag, "_vec"},  32'(vec_v),  32'(0));
        check_eq({tag, "_tt"},   32'(tt_v),   32'(0));
        check_eq({tag, "_pass"}, 32'(pass_v), 32'(0));
    endtask

    // Full sweep; optional re-pulses of start mid-sweep and in the DONE cycle.
    task automatic run_sweep(input bit use_b, input logic [7:0] code,
                             input logic [7:0] exp_code, input bit repulse);
        int s;
        int last;
        sel = use_b;
        s = use_b ? S_B : S_A;
        last = 8 * s;
        if (use_b) code_b = code;
        else       code_a = code;
        expected = exp_code;
        exp_q.push_back(code);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        expected = ~exp_code;
        check_eq("pass_cleared", 32'(pass_v), 32'(0));
        for (int t = 0; t <= last + 2; t++) begin
            check_eq("vec", 32'(vec_v), (t < last) ? 32'(t / s) : (t == last) ? 32'(7) : 32'(0));
            check_eq("busy", 32'(busy_v), 32'(t <= last));
            check_eq("done", 32'(done_v), 32'(t == last));
            if (done_v) begin
                check_eq("sb_depth", 32'(exp_q.size()), 32'(1));
                if (exp_q.size() > 0) check_eq("truth_table", 32'(tt_v), 32'(exp_q.pop_front()));
                check_eq("pass", 32'(pass_v), 32'(code == exp_code));
            end
            if (t > last) begin
                check_eq("tt_held", 32'(tt_v), 32'(code));
                check_eq("pass_held", 32'(pass_v), 32'(code == exp_code));
            end
            if (repulse && (t == 4 || t == last)) set_start(1'b1);
            tick();
            set_start(1'b0);
        end
    endtask

    initial begin
        int done_seen;

        // Reset
        rst_n = 1'b0;
        tick();
        tick();
        sel = 1'b0;
        check_idle_outputs("rst_a");
        check_eq("rst_a_state", 32'(st_v), 32'(IDLE));
        sel = 1'b1;
        check_idle_outputs("rst_b");
        check_eq("rst_b_state", 32'(st_v), 32'(IDLE));
        rst_n = 1'b1;
        tick();

        // 1, 2: matching and non-matching expected code
        run_sweep(1'b0, 8'hB7, 8'hB7, 1'b0);
        run_sweep(1'b0, 8'hB7, 8'hB6, 1'b0);

        // 3: start re-pulsed mid-sweep and in the DONE cycle
        run_sweep(1'b0, 8'h5A, 8'h5A, 1'b1);
        check_eq("repulse_idle", 32'(busy_v), 32'(0));

        // abort and start together in IDLE: abort wins
        sel = 1'b0;
        start_a = 1'b1;
        abort = 1'b1;
        tick();
        start_a = 1'b0;
        abort = 1'b0;
        check_eq("abort_start_busy", 32'(busy_v), 32'(0));
        check_eq("abort_start_state", 32'(st_v), 32'(IDLE));

        // 4: abort during vector 010
        code_a = 8'hB7;
        expected = 8'hB7;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int t = 0; t < 9; t++) tick();
        check_eq("pre_abort_vec", 32'(vec_v), 32'(2));
        check_eq("pre_abort_tt", 32'(tt_v), 32'(8'h80));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle_outputs("abort");
        check_eq("abort_state", 32'(st_v), 32'(IDLE));
        done_seen = 0;
        for (int t = 0; t < 40; t++) begin
            if (done_v) done_seen++;
            tick();
        end
        check_eq("abort_no_done", 32'(done_seen), 32'(0));
        run_sweep(1'b0, 8'hB7, 8'hB7, 1'b0);

        // 5: asynchronous reset mid-sweep
        code_a = 8'h3C;
        expected = 8'h3C;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int t = 0; t < 19; t++) tick();
        check_eq("pre_rst_tt", 32'(tt_v), 32'(8'h30));
        check_eq("pre_rst_busy", 32'(busy_v), 32'(1));
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            check_eq("post_rst_busy", 32'(busy_v), 32'(0));
            check_eq("post_rst_state", 32'(st_v), 32'(IDLE));
        end

        // 6: single-cycle settle, constant gates
        run_sweep(1'b1, 8'h00, 8'h00, 1'b0);
        run_sweep(1'b1, 8'hFF, 8'hFF, 1'b0);

        // Report
        check_eq("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
